// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and command/response record types.
package ahb_pkg;

  localparam int AHB_ADDR_W = 32;
  localparam int AHB_DATA_W = 32;

  typedef logic [1:0] htrans_t;

  localparam htrans_t HTRANS_IDLE   = 2'b00;
  localparam htrans_t HTRANS_NONSEQ = 2'b10;

  // One command as offered on the cmd stream.
  typedef struct packed {
    logic                  write;
    logic [AHB_ADDR_W-1:0] addr;
    logic [AHB_DATA_W-1:0] wdata;
  } cmd_t;

  // One completion as returned on the rsp stream.
  typedef struct packed {
    logic                  write;
    logic [AHB_DATA_W-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/ahb_cmd_master_if.sv
// Command/response streams plus AHB-Lite manager bus, bundled for port lists.
interface ahb_cmd_master_if
  import ahb_pkg::*;
#(
  parameter int ADDR_W = AHB_ADDR_W,
  parameter int DATA_W = AHB_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;

  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  htrans_t           HTRANS;
  logic              HWRITE;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;

  // The command master's own view.
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, HRDATA, HREADY,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata,
           HSEL, HADDR, HTRANS, HWRITE, HWDATA
  );

  // The environment: command source, response sink and bus responder.
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, HRDATA, HREADY,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata,
           HSEL, HADDR, HTRANS, HWRITE, HWDATA
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; output reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_pop;

  assign do_pop  = pop_i && valid_o;
  assign valid_o = (cnt_q != '0);
  assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = cnt_q;

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers and count; power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage array, written on push only.
  always_ff @(posedge HCLK) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  // The upstream credit scheme must never push into a full queue.
  a_no_overflow: assert property (@(posedge HCLK) disable iff (!HRESETn)
    push_i |-> (cnt_q < FULL));

endmodule

// File: rtl/ahb_cmd_master.sv
// AHB-Lite manager: cmd stream -> pipelined single-word transfers -> rsp stream.
module ahb_cmd_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W    = AHB_ADDR_W,
  parameter int DATA_W    = AHB_DATA_W,
  parameter int RSP_DEPTH = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_cmd_master_if.master bus
);
  localparam int             CNT_W   = $clog2(RSP_DEPTH) + 1;
  localparam logic [CNT_W:0] CREDITS = (CNT_W+1)'(RSP_DEPTH);

  // Address-phase stage A and data-phase stage D.
  logic              a_vld_q, a_vld_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic              a_write_q, a_write_d;
  logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
  logic              d_vld_q, d_vld_d;
  logic              d_write_q, d_write_d;
  logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
  logic              rdy_en_q;

  logic              accept, push, pop, cmd_ready;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W:0]    credit_used;
  logic [DATA_W:0]   push_data, fifo_dout;
  logic              fifo_valid;

  // Every transfer in either stage already owns a FIFO slot; a pop this
  // cycle is deliberately not credited until the count actually drops.
  assign credit_used = {{CNT_W{1'b0}}, a_vld_q} + {{CNT_W{1'b0}}, d_vld_q}
                     + {1'b0, fifo_cnt};
  assign cmd_ready   = rdy_en_q && (!a_vld_q || bus.HREADY) && (credit_used < CREDITS);
  assign accept      = bus.cmd_valid && cmd_ready;
  assign push        = bus.HREADY && d_vld_q;
  assign push_data   = {d_write_q, d_write_q ? {DATA_W{1'b0}} : bus.HRDATA};
  assign pop         = fifo_valid && bus.rsp_ready;

  // Pipeline advance: A reloads when empty or its address phase completes; D follows A on HREADY.
  always_comb begin
    a_vld_d   = a_vld_q;
    a_addr_d  = a_addr_q;
    a_write_d = a_write_q;
    a_wdata_d = a_wdata_q;
    d_vld_d   = d_vld_q;
    d_write_d = d_write_q;
    d_wdata_d = d_wdata_q;
    if (!a_vld_q || bus.HREADY) begin
      a_vld_d = accept;
      if (accept) begin
        a_addr_d  = bus.cmd_addr;
        a_write_d = bus.cmd_write;
        a_wdata_d = bus.cmd_wdata;
      end
    end
    if (bus.HREADY) begin
      d_vld_d   = a_vld_q;
      d_write_d = a_write_q;
      // Write data only changes when a write enters the data phase, so
      // HWDATA otherwise keeps its last value.
      if (a_vld_q && a_write_q) d_wdata_d = a_wdata_q;
    end
  end

  // Pipeline registers; reset drops the bus to IDLE at once and discards in-flight work.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_vld_q   <= 1'b0;
      a_addr_q  <= '0;
      a_write_q <= 1'b0;
      a_wdata_q <= '0;
      d_vld_q   <= 1'b0;
      d_write_q <= 1'b0;
      d_wdata_q <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      a_vld_q   <= a_vld_d;
      a_addr_q  <= a_addr_d;
      a_write_q <= a_write_d;
      a_wdata_q <= a_wdata_d;
      d_vld_q   <= d_vld_d;
      d_write_q <= d_write_d;
      d_wdata_q <= d_wdata_d;
      rdy_en_q  <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .valid_o (fifo_valid),
    .count_o (fifo_cnt)
  );

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = fifo_valid;
  assign bus.rsp_write = fifo_dout[DATA_W];
  assign bus.rsp_rdata = fifo_dout[DATA_W-1:0];
  assign bus.HSEL      = a_vld_q;
  assign bus.HTRANS    = a_vld_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = a_addr_q;
  assign bus.HWRITE    = a_write_q;
  assign bus.HWDATA    = d_wdata_q;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench: zero/wait-state responder, in-order response and write logs.
module tb_ahb_cmd_master;
  import ahb_pkg::*;

  localparam int AW = 32, DW = 32, DEPTH = 4;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  ahb_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ahb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(DEPTH)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  logic          cmd_valid, cmd_write, rsp_ready, hready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata, gpio_in;

  assign bus.cmd_valid = cmd_valid;
  assign bus.cmd_write = cmd_write;
  assign bus.cmd_addr  = cmd_addr;
  assign bus.cmd_wdata = cmd_wdata;
  assign bus.rsp_ready = rsp_ready;
  assign bus.HREADY    = hready;

  // Responder: address 0 reads the GPIO input, others read addr ^ 5A5A0000.
  logic          sl_vld, sl_write;
  logic [AW-1:0] sl_addr;
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sl_vld <= 1'b0; sl_write <= 1'b0; sl_addr <= '0;
    end else if (bus.HREADY) begin
      sl_vld   <= bus.HSEL && (bus.HTRANS == HTRANS_NONSEQ);
      sl_write <= bus.HWRITE;
      sl_addr  <= bus.HADDR;
    end
  end
  assign bus.HRDATA = (sl_addr == '0) ? gpio_in : (sl_addr ^ 32'h5A5A_0000);

  rsp_t        rsp_q[$];
  logic [63:0] wr_q[$];
  int          n_acc, run, max_run, cyc;
  int          n_chk = 0, n_fail = 0;
  bit          bp_done;

  always @(posedge HCLK) cyc++;

  // Monitors, sampled mid-cycle.
  always @(negedge HCLK) begin
    if (bus.rsp_valid && rsp_ready) rsp_q.push_back(rsp_t'{write: bus.rsp_write, rdata: bus.rsp_rdata});
    if (sl_vld && sl_write && bus.HREADY) wr_q.push_back({sl_addr, bus.HWDATA});
    if (cmd_valid && bus.cmd_ready) n_acc++;
    if (bus.HTRANS == HTRANS_NONSEQ) begin
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Offer one command; returns 1 time unit after the accepting edge.
  task automatic send(input cmd_t c);
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = c.write; cmd_addr = c.addr; cmd_wdata = c.wdata;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge HCLK);
      ok = bus.cmd_ready;
    end
    @(posedge HCLK); #1;
    chk($sformatf("accept_%h", c.addr), 64'(ok), 64'd1);
  endtask

  function automatic rsp_t rsp_at(input int i);
    return (i < rsp_q.size()) ? rsp_q[i] : '1;
  endfunction

  function automatic logic [63:0] wr_at(input int i);
    return (i < wr_q.size()) ? wr_q[i] : '1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40;
    cmd_wdata = 32'h55; rsp_ready = 1'b0; hready = 1'b1; gpio_in = 32'h0;
    #1 HRESETn = 1'b0;

    // Reset held with a command offered: bus must stay idle.
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      chk("rst_htrans", 64'(bus.HTRANS), 64'(HTRANS_IDLE));
      chk("rst_hsel",   64'(bus.HSEL), 0);
      chk("rst_ready",  64'(bus.cmd_ready), 0);
      chk("rst_rvalid", 64'(bus.rsp_valid), 0);
    end
    chk("rst_haddr",  64'(bus.HADDR), 0);
    chk("rst_hwrite", 64'(bus.HWRITE), 0);
    chk("rst_hwdata", 64'(bus.HWDATA), 0);
    chk("rst_rwrite", 64'(bus.rsp_write), 0);
    chk("rst_rdata",  64'(bus.rsp_rdata), 0);
    @(posedge HCLK); #1;
    cmd_valid = 1'b0; HRESETn = 1'b1; rsp_ready = 1'b1;
    tick(2);

    // Single write, cycle-exact.
    rsp_q.delete(); wr_q.delete();
    send(cmd_t'{1'b1, 32'h4, 32'hA5});
    cmd_valid = 1'b0;
    @(negedge HCLK);
    chk("w1_htrans", 64'(bus.HTRANS), 64'(HTRANS_NONSEQ));
    chk("w1_hsel",   64'(bus.HSEL), 1);
    chk("w1_haddr",  64'(bus.HADDR), 64'h4);
    chk("w1_hwrite", 64'(bus.HWRITE), 1);
    @(negedge HCLK);
    chk("w1_hwdata", 64'(bus.HWDATA), 64'hA5);
    chk("w1_rvalid_early", 64'(bus.rsp_valid), 0);
    @(negedge HCLK);
    chk("w1_rvalid", 64'(bus.rsp_valid), 1);
    chk("w1_rwrite", 64'(bus.rsp_write), 1);
    chk("w1_rdata",  64'(bus.rsp_rdata), 0);
    tick(2);
    chk("w1_nrsp", 64'(rsp_q.size()), 1);
    chk("w1_wlog", wr_at(0), {32'h4, 32'hA5});

    // Write then GPIO read, in order.
    rsp_q.delete();
    gpio_in = 32'h1234;
    send(cmd_t'{1'b1, 32'h8, 32'hDEAD_BEEF});
    send(cmd_t'{1'b0, 32'h0, 32'h0});
    cmd_valid = 1'b0;
    tick(6);
    chk("rd_nrsp", 64'(rsp_q.size()), 2);
    chk("rd_rsp0", 64'(rsp_at(0)), 64'(rsp_t'{1'b1, 32'h0}));
    chk("rd_rsp1", 64'(rsp_at(1)), 64'(rsp_t'{1'b0, 32'h1234}));

    // Back-to-back alternating write/read, zero wait.
    begin
      int t0;
      rsp_q.delete(); wr_q.delete(); max_run = 0;
      t0 = cyc;
      for (int i = 0; i < 8; i++)
        send(cmd_t'{(i % 2) == 0, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i)});
      chk("b2b_cycles", 64'(cyc - t0), 8);
      cmd_valid = 1'b0;
      tick(6);
      chk("b2b_run", 64'(max_run), 8);
      chk("b2b_nrsp", 64'(rsp_q.size()), 8);
      for (int i = 0; i < 8; i++)
        chk($sformatf("b2b_rsp%0d", i), 64'(rsp_at(i)),
            (i % 2 == 0) ? 64'(rsp_t'{1'b1, 32'h0})
                         : 64'(rsp_t'{1'b0, 32'h5A5A_0100 + 32'(4 * i)}));
      chk("b2b_nwr", 64'(wr_q.size()), 4);
      for (int j = 0; j < 4; j++)
        chk($sformatf("b2b_wr%0d", j), wr_at(j),
            {32'h100 + 32'(8 * j), 32'hC0DE_0000 + 32'(2 * j)});
    end

    // Two-cycle wait state mid-stream.
    rsp_q.delete(); wr_q.delete();
    fork
      begin
        send(cmd_t'{1'b1, 32'h200, 32'h1111_1111});
        send(cmd_t'{1'b0, 32'h204, 32'h0});
        send(cmd_t'{1'b1, 32'h208, 32'h2222_2222});
        send(cmd_t'{1'b0, 32'h20C, 32'h0});
      end
      begin
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        hready = 1'b0;
        for (int s = 1; s <= 2; s++) begin
          @(negedge HCLK);
          chk($sformatf("stall%0d_htrans", s), 64'(bus.HTRANS), 64'(HTRANS_NONSEQ));
          chk($sformatf("stall%0d_haddr", s),  64'(bus.HADDR), 64'h204);
          chk($sformatf("stall%0d_hwrite", s), 64'(bus.HWRITE), 0);
          chk($sformatf("stall%0d_hwdata", s), 64'(bus.HWDATA), 64'h1111_1111);
          @(posedge HCLK); #1;
        end
        hready = 1'b1;
      end
    join
    cmd_valid = 1'b0;
    tick(8);
    chk("ws_nrsp", 64'(rsp_q.size()), 4);
    chk("ws_rsp0", 64'(rsp_at(0)), 64'(rsp_t'{1'b1, 32'h0}));
    chk("ws_rsp1", 64'(rsp_at(1)), 64'(rsp_t'{1'b0, 32'h5A5A_0204}));
    chk("ws_rsp2", 64'(rsp_at(2)), 64'(rsp_t'{1'b1, 32'h0}));
    chk("ws_rsp3", 64'(rsp_at(3)), 64'(rsp_t'{1'b0, 32'h5A5A_020C}));
    chk("ws_nwr",  64'(wr_q.size()), 2);
    chk("ws_wr0",  wr_at(0), {32'h200, 32'h1111_1111});
    chk("ws_wr1",  wr_at(1), {32'h208, 32'h2222_2222});

    // Response backpressure: only RSP_DEPTH commands may be accepted.
    rsp_q.delete(); rsp_ready = 1'b0; n_acc = 0; bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(cmd_t'{1'b0, 32'h300 + 32'(4 * i), 32'h0});
        cmd_valid = 1'b0;
        bp_done = 1'b1;
      end
    join_none
    tick(15);
    @(negedge HCLK);
    chk("bp_nacc",   64'(n_acc), 4);
    chk("bp_ready",  64'(bus.cmd_ready), 0);
    chk("bp_rvalid", 64'(bus.rsp_valid), 1);
    @(posedge HCLK); #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && !bp_done; i++) tick(1);
    chk("bp_done", 64'(bp_done), 1);
    tick(8);
    chk("bp_nacc_all", 64'(n_acc), 6);
    chk("bp_nrsp", 64'(rsp_q.size()), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("bp_rsp%0d", i), 64'(rsp_at(i)),
          64'(rsp_t'{1'b0, 32'h5A5A_0300 + 32'(4 * i)}));

    // Reset with a transfer in its address phase.
    rsp_q.delete(); wr_q.delete();
    send(cmd_t'{1'b1, 32'h400, 32'h77});
    cmd_valid = 1'b0;
    chk("mrst_pre_htrans", 64'(bus.HTRANS), 64'(HTRANS_NONSEQ));
    HRESETn = 1'b0;
    #1;
    chk("mrst_htrans", 64'(bus.HTRANS), 64'(HTRANS_IDLE));
    chk("mrst_hsel",   64'(bus.HSEL), 0);
    chk("mrst_ready",  64'(bus.cmd_ready), 0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    tick(6);
    chk("mrst_nrsp",   64'(rsp_q.size()), 0);
    chk("mrst_rvalid", 64'(bus.rsp_valid), 0);
    chk("mrst_nwr",    64'(wr_q.size()), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
